// File: rtl/reset_ce_gen_pkg.sv
// rtl/reset_ce_gen_pkg.sv - state type, counter-width helper and RST_COUNT width for reset_ce_gen
package reset_ce_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int RST_COUNT_W = 8;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_ce_gen_if.sv
// rtl/reset_ce_gen_if.sv - soft-reset request in, SR_OUT/CE_OUT/READY out; RST_COUNT when RESET_CNT_EN
interface reset_ce_gen_if;
    import reset_ce_pkg::*;

    logic RST_REQ;
    logic SR_OUT;
    logic CE_OUT;
    logic READY;
`ifdef RESET_CNT_EN
    logic [RST_COUNT_W-1:0] RST_COUNT;

    modport master (input RST_REQ, output SR_OUT, output CE_OUT, output READY, output RST_COUNT);
    modport slave  (output RST_REQ, input SR_OUT, input CE_OUT, input READY, input RST_COUNT);
`else
    modport master (input RST_REQ, output SR_OUT, output CE_OUT, output READY);
    modport slave  (output RST_REQ, input SR_OUT, input CE_OUT, input READY);
`endif

endinterface

// File: rtl/reset_ce_gen_sync.sv
// rtl/reset_ce_gen_sync.sv - async-assert / sync-deassert reset synchroniser chain
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CK,
    input  logic SR,
    output logic SYNC_SR
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign SYNC_SR = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_ce_gen.sv
// rtl/reset_ce_gen.sv - reset release sequencer and CE strobe divider; RESET_CNT_EN adds RST_COUNT
module reset_ce_gen
    import reset_ce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CE_DIV      = 4
) (
    input  logic           CK,
    input  logic           SR,
    reset_ce_gen_if.master bus
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int DW = cnt_width(CE_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CE_DIV - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_ce_gen: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_ce_gen: HOLD_CYCLES must be >= 1");
        end
        if (CE_DIV < 1) begin : g_bad_div
            $error("reset_ce_gen: CE_DIV must be >= 1");
        end
    endgenerate

    logic sync_sr;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CK      (CK),
        .SR      (SR),
        .SYNC_SR (sync_sr)
    );

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sr_out_q, sr_out_d;
    logic            ce_q, ce_d;
    logic            ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            RESET: begin
                // The edge that sees the chain release already counts as the first hold cycle.
                if (!sync_sr) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HW'(1);
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RESET;
                hold_d  = '0;
            end
        endcase
        if (bus.RST_REQ) begin
            state_d = HOLD;
            hold_d  = '0;
        end

        div_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        ce_d     = (state_q == RUN) && (state_d == RUN) && (div_q == DIV_LAST);
        sr_out_d = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            state_q  <= RESET;
            hold_q   <= '0;
            div_q    <= '0;
            sr_out_q <= 1'b1;
            ce_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            div_q    <= div_d;
            sr_out_q <= sr_out_d;
            ce_q     <= ce_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.SR_OUT = sr_out_q;
    assign bus.CE_OUT = ce_q;
    assign bus.READY  = ready_q;

`ifdef RESET_CNT_EN
    logic [RST_COUNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                   hold_entry;

    always_comb begin
        hold_entry = ((state_q == RESET) && (state_d != RESET)) ||
                     (bus.RST_REQ && (state_q == RUN));
        rst_cnt_d  = rst_cnt_q;
        if (hold_entry && (rst_cnt_q != '1)) begin
            rst_cnt_d = rst_cnt_q + RST_COUNT_W'(1);
        end
    end

    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            rst_cnt_q <= '0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign bus.RST_COUNT = rst_cnt_q;
`endif

endmodule

// File: tb/tb_reset_ce_gen.sv
// tb/tb_reset_ce_gen.sv - randomized bench with release-edge reference model for reset_ce_gen
`timescale 1ns/1ps
module tb_reset_ce_gen;
    import reset_ce_pkg::*;

    logic CK;
    logic SR;
    logic rst_req;
    int   n_cmp;
    int   n_bad;

    reset_ce_gen_if bus_a ();
    reset_ce_gen_if bus_b ();
    assign bus_a.RST_REQ = rst_req;
    assign bus_b.RST_REQ = rst_req;

    reset_ce_gen dut_a (.CK(CK), .SR(SR), .bus(bus_a));
    reset_ce_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .CE_DIV(1)) dut_b (.CK(CK), .SR(SR), .bus(bus_b));

    initial begin
        CK = 1'b0;
        #1000;
        forever #100 CK = ~CK;
    end

    // Model: edges since SR released, and the edge on which SR_OUT must fall.
    int m_s [2] = '{2, 3};
    int m_h [2] = '{16, 1};
    int m_d [2] = '{4, 1};
    int m_n [2];
    int m_r [2];
    int m_cnt [2];
    bit m_req [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] outs(input int k);
        return (k == 0) ? {bus_a.SR_OUT, bus_a.CE_OUT, bus_a.READY}
                        : {bus_b.SR_OUT, bus_b.CE_OUT, bus_b.READY};
    endfunction

    task automatic model_reset(input int k);
        m_n[k]   = 0;
        m_r[k]   = m_s[k] + m_h[k];
        m_cnt[k] = 0;
        m_req[k] = 1'b0;
    endtask

    task automatic model_edge(input int k, input bit req);
        int  n;
        bit  pre_reset;
        bit  pre_run;
        m_n[k]    = m_n[k] + 1;
        n         = m_n[k];
        pre_reset = !m_req[k] && (n <= m_s[k] + 1);
        pre_run   = (n - 1) >= m_r[k];
        if ((pre_reset && (req || n == m_s[k] + 1)) || (req && pre_run)) begin
            if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
        end
        if (req) begin
            m_req[k] = 1'b1;
            m_r[k]   = n + m_h[k];
        end
    endtask

    task automatic compare(input int k);
        logic [2:0] o;
        bit e_sr;
        bit e_ce;
        o    = outs(k);
        e_sr = m_n[k] < m_r[k];
        e_ce = (m_n[k] > m_r[k]) && (((m_n[k] - m_r[k]) % m_d[k]) == 0);
        check($sformatf("sr_out[%0d] edge %0d", k, m_n[k]), o[2], e_sr);
        check($sformatf("ce_out[%0d] edge %0d", k, m_n[k]), o[1], e_ce);
        check($sformatf("ready[%0d] edge %0d", k, m_n[k]), o[0], !e_sr);
        check($sformatf("ce_with_sr[%0d]", k), o[2] & o[1], 1'b0);
`ifdef RESET_CNT_EN
        check($sformatf("rst_count[%0d] edge %0d", k, m_n[k]),
              (k == 0) ? bus_a.RST_COUNT : bus_b.RST_COUNT, m_cnt[k]);
`endif
    endtask

    task automatic tick();
        @(posedge CK);
        for (int k = 0; k < 2; k++) begin
            if (SR) model_reset(k);
            else    model_edge(k, rst_req);
        end
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sr_a"}, bus_a.SR_OUT, 1'b1);
        check({tag, "_ce_a"}, bus_a.CE_OUT, 1'b0);
        check({tag, "_rdy_a"}, bus_a.READY, 1'b0);
        check({tag, "_sr_b"}, bus_b.SR_OUT, 1'b1);
        check({tag, "_ce_b"}, bus_b.CE_OUT, 1'b0);
        check({tag, "_rdy_b"}, bus_b.READY, 1'b0);
    endtask

    initial begin
        int fall_a;
        int fall_b;
        int b_gap;
        int w;
        int req_left;
        int ce_a [$];

        n_cmp   = 0;
        n_bad   = 0;
        rst_req = 1'b0;
        SR      = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        #50;
        check_reset_vals("por_sr_high");
        #50 SR = 1'b0;
        #400;
        check_reset_vals("por_no_edge");

        fall_a = 0;
        fall_b = 0;
        b_gap  = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (fall_a == 0 && bus_a.SR_OUT === 1'b0) fall_a = i;
            if (fall_b == 0 && bus_b.SR_OUT === 1'b0) fall_b = i;
            if (bus_a.CE_OUT === 1'b1) ce_a.push_back(i);
            if (i > 4 && bus_b.CE_OUT !== 1'b1) b_gap++;
        end
        check("por_fall_a", fall_a, 18);
        check("por_fall_b", fall_b, 4);
        check("ce_pulse_count", ce_a.size(), 3);
        while (ce_a.size() < 3) ce_a.push_back(-1);
        check("ce_pulse_0", ce_a[0], 22);
        check("ce_pulse_1", ce_a[1], 26);
        check("ce_pulse_2", ce_a[2], 30);
        check("ce_b_constant", b_gap, 0);
`ifdef RESET_CNT_EN
        check("por_count_a", bus_a.RST_COUNT, 1);
`endif

        #49 SR = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        #1;
        check_reset_vals("async_pulse");
        #29 SR = 1'b0;
        fall_a = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fall_a == 0 && bus_a.SR_OUT === 1'b0) fall_a = i;
        end
        check("async_release", fall_a, 18);

`ifdef RESET_CNT_EN
        check("soft_count_before", bus_a.RST_COUNT, 1);
`endif
        rst_req = 1'b1;
        tick();
        check("soft_first_edge_sr", bus_a.SR_OUT, 1'b1);
        check("soft_first_edge_ce", bus_a.CE_OUT, 1'b0);
        tick();
        tick();
        rst_req = 1'b0;
        fall_a  = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (fall_a == 0 && bus_a.SR_OUT === 1'b0) fall_a = i;
        end
        check("soft_release", fall_a, 16);
`ifdef RESET_CNT_EN
        check("soft_count_after", bus_a.RST_COUNT, 2);
`endif

        SR      = 1'b1;
        rst_req = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        tick();
        tick();
        check("prio_sr_out", bus_a.SR_OUT, 1'b1);
        SR      = 1'b0;
        rst_req = 1'b0;
        fall_a  = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (fall_a == 0 && bus_a.SR_OUT === 1'b0) fall_a = i;
        end
        check("prio_release", fall_a, 18);

        req_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (req_left > 0) begin
                rst_req  = 1'b1;
                req_left = req_left - 1;
            end else begin
                rst_req = 1'b0;
                if ($urandom_range(0, 39) == 0) req_left = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 149) == 0) begin
                #($urandom_range(20, 60));
                SR = 1'b1;
                for (int k = 0; k < 2; k++) model_reset(k);
                #1;
                check_reset_vals("rand_sr");
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    #($urandom_range(20, 60));
                end else begin
                    #20;
                end
                SR = 1'b0;
            end
            tick();
        end

`ifdef RESET_CNT_EN
        rst_req = 1'b0;
        #40 SR = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        #20 SR = 1'b0;
        for (int p = 0; p < 300; p++) begin
            rst_req = 1'b1;
            tick();
            rst_req = 1'b0;
            w = 0;
            while (bus_a.READY !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            check("sat_ready_wait", w < 40, 1'b1);
        end
        check("rst_count_sat_a", bus_a.RST_COUNT, 255);
        check("rst_count_sat_b", bus_b.RST_COUNT, 255);
        #40 SR = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        #1;
        check("rst_count_cleared", bus_a.RST_COUNT, 0);
        #20 SR = 1'b0;
`endif

        rst_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
